// File: rtl/ram_page_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Package : ram_stream_pkg
//  Purpose : Shared types and constants for the RAM page streamer: the
//            control FSM encoding, prefetch FIFO depth and the read-issue
//            credit limit.
//  Rev     : 1.0  initial release
// ============================================================================
package ram_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int FIFO_DEPTH   = 4;
    // A read may be issued only while (fifo_count + inflight) stays at or
    // below this value, so the returning word always finds a free slot.
    localparam int ISSUE_CREDIT = 2;

endpackage
`default_nettype wire

// File: rtl/ram_page_streamer_if.sv
`default_nettype none
// ============================================================================
//  Interface : ram_page_streamer_if
//  Purpose   : Bundles the command, RAM read-port and output stream signals
//              of the RAM page streamer.
//  Signals   : start/start_addr/word_count  command (slave -> master)
//              busy/done                    status  (master -> slave)
//              ram_rd_addr / ram_rd_data    RAM read port
//              out_data/out_valid/out_last  stream (master -> slave)
//              out_ready                    stream backpressure (slave -> master)
//  Modports  : master = streamer side, slave = parent/consumer side
//  Rev       : 1.0  initial release
// ============================================================================
interface ram_page_streamer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);

    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] ram_rd_addr;
    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        input  start, start_addr, word_count, ram_rd_data, out_ready,
        output busy, done, ram_rd_addr, out_data, out_valid, out_last
    );

    modport slave (
        output start, start_addr, word_count, ram_rd_data, out_ready,
        input  busy, done, ram_rd_addr, out_data, out_valid, out_last
    );

endinterface
`default_nettype wire

// File: rtl/ram_page_streamer_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : stream_fifo
//  Purpose : Small synchronous FIFO used as the prefetch buffer between the
//            RAM read port and the output stream. Push and pop may happen in
//            the same cycle; pushes while full and pops while empty are
//            ignored.
//  Ports   : clk, rst      clock, synchronous active-high reset
//            i_push/i_push_data   write side
//            i_pop                read side (head advances)
//            o_head               current head entry
//            o_count              number of stored entries
//            o_empty              no entries stored
//  Rev     : 1.0  initial release
// ============================================================================
module stream_fifo
    import ram_stream_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [WIDTH-1:0]           i_push_data,
    input  wire logic                       i_pop,
    output logic      [WIDTH-1:0]           o_head,
    output logic      [$clog2(DEPTH):0]     o_count,
    output logic                            o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_pop;
    logic               w_push;

    // Pointers wrap naturally because DEPTH is a power of two.
    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != c_CNT_MAX) || w_pop);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_page_streamer.sv
`default_nettype none
// ============================================================================
//  Module  : ram_page_streamer
//  Purpose : Read-side engine of the dual-clock RAM buffer. On a start command
//            it reads word_count words starting at start_addr from the RAM
//            read port (1-cycle registered latency) and emits them as a
//            valid/ready stream with out_last on the final word. A 4-entry
//            prefetch FIFO hides RAM latency and consumer backpressure.
//  Ports   : clock   single clock, also drives the RAM read clock
//            reset   synchronous, active-high
//            bus     ram_page_streamer_if.master (command, status, RAM read
//                    port, output stream)
//  Rev     : 1.0  initial release
// ============================================================================
module ram_page_streamer
    import ram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input wire logic            clock,
    input wire logic            reset,
    ram_page_streamer_if.master bus
);

    localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CNT_W:0]     c_ISSUE_CREDIT = (c_CNT_W+1)'(ISSUE_CREDIT);
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   c_REM_ONE     = (ADDR_WIDTH+1)'(1);

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_issue_rem;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  w_issue;
    logic [c_CNT_W:0]      w_credit_used;

    logic [DATA_WIDTH:0]   w_head;
    logic [c_CNT_W-1:0]    w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic                  w_head_last;

    // Credit uses registered state only, so out_ready never reaches ram_rd_addr
    // combinationally.
    assign w_credit_used = {1'b0, w_fifo_count} + {{c_CNT_W{1'b0}}, r_inflight};
    assign w_issue       = (r_state == S_ISSUE) && (r_issue_rem != '0) &&
                           (w_credit_used <= c_ISSUE_CREDIT);

    assign w_head_last = w_head[DATA_WIDTH] && !w_fifo_empty;
    assign w_pop       = !w_fifo_empty && bus.out_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.word_count != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (w_issue && (r_issue_rem == c_REM_ONE)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------- address / issue path
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr          <= '0;
            r_issue_rem     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && bus.start) begin
                r_addr      <= bus.start_addr;
                r_issue_rem <= bus.word_count;
            end else if (w_issue) begin
                // Natural wrap of the address counter gives modulo addressing.
                r_addr      <= r_addr + c_ADDR_ONE;
                r_issue_rem <= r_issue_rem - c_REM_ONE;
            end
            // The word returning next cycle is tagged last if this was the
            // final read of the transfer.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue_rem == c_REM_ONE);
        end
    end

    // ----------------------------------------------------- prefetch buffer
    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst         (reset),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, bus.ram_rd_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty)
    );

    // ------------------------------------------------------------- outputs
    assign bus.ram_rd_addr = r_addr;
    assign bus.out_valid   = !w_fifo_empty;
    assign bus.out_data    = w_head[DATA_WIDTH-1:0];
    assign bus.out_last    = w_head_last;
    assign bus.busy        = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bus.done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_page_streamer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ram_page_streamer
//  Purpose : Self-checking bench for ram_page_streamer. A RAM model with a
//            1-cycle registered read is preloaded with A500_0000+i; expected
//            stream beats are queued when a transfer starts and popped by a
//            monitor on every handshake.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_ram_page_streamer;

    logic clock;
    logic reset;

    ram_page_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bif ();

    ram_page_streamer #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    logic [31:0] ram [256];
    logic [32:0] sb [$];

    int vectors;
    int miscompares;
    int beats_seen;
    int done_count;

    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        bif.ram_rd_data <= ram[bif.ram_rd_addr];
    end

    // Scoreboard monitor: compares every handshake and checks hold-while-stalled.
    always @(negedge clock) begin
        logic [32:0] exp_v;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                vectors++;
                if (!bif.out_valid || bif.out_data !== prev_data || bif.out_last !== prev_last) begin
                    miscompares++;
                    $display("FAIL stall_hold: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                             bif.out_valid, bif.out_data, bif.out_last, prev_data, prev_last);
                end
            end
            if (bif.out_valid && bif.out_ready) begin
                beats_seen++;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL beat_unexpected: got data=%h last=%b, expected no beat",
                             bif.out_data, bif.out_last);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bif.out_last, bif.out_data} !== exp_v) begin
                        miscompares++;
                        $display("FAIL beat_data: got last=%b data=%h, expected last=%b data=%h",
                                 bif.out_last, bif.out_data, exp_v[32], exp_v[31:0]);
                    end
                end
            end
            if (bif.done) done_count++;
            prev_stall = bif.out_valid && !bif.out_ready;
            prev_data  = bif.out_data;
            prev_last  = bif.out_last;
        end
    end

    task automatic load_expect(input logic [7:0] addr, input int n);
        logic [7:0] a;
        a = addr;
        for (int i = 0; i < n; i++) begin
            sb.push_back({(i == n - 1), ram[a]});
            a = a + 8'd1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] addr, input logic [8:0] cnt);
        @(posedge clock); #1;
        bif.start      = 1'b1;
        bif.start_addr = addr;
        bif.word_count = cnt;
        @(posedge clock); #1;
        bif.start = 1'b0;
    endtask

    task automatic wait_for_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clock);
            if (bif.done) ok = 1'b1;
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b, expected 0", bif.busy); end
        vectors++; if (bif.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b, expected 0", bif.done); end
        vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, expected 0", bif.out_valid); end
        vectors++; if (bif.out_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b, expected 0", bif.out_last); end
        vectors++; if (bif.out_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h, expected 0", bif.out_data); end
        vectors++; if (bif.ram_rd_addr !== 8'h0) begin miscompares++; $display("FAIL reset_addr: got %h, expected 0", bif.ram_rd_addr); end
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_count;
        bif.out_ready = 1'b1;
        load_expect(8'h10, 4);
        pulse_start(8'h10, 9'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            vectors++;
            if (bif.out_valid !== ((k >= 3) && (k <= 6))) begin
                miscompares++;
                $display("FAIL basic_valid_c%0d: got %b, expected %b", k, bif.out_valid, ((k >= 3) && (k <= 6)));
            end
            vectors++;
            if (bif.done !== (k == 7)) begin
                miscompares++;
                $display("FAIL basic_done_c%0d: got %b, expected %b", k, bif.done, (k == 7));
            end
            if (k == 1) begin
                vectors++;
                if (bif.ram_rd_addr !== 8'h10) begin miscompares++; $display("FAIL basic_addr: got %h, expected 10", bif.ram_rd_addr); end
                vectors++;
                if (bif.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b, expected 1", bif.busy); end
            end
        end
        @(posedge clock); #1;
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL basic_leftover: got %0d, expected 0", sb.size()); end
        vectors++; if (done_count - d0 != 1) begin miscompares++; $display("FAIL basic_done_pulses: got %0d, expected 1", done_count - d0); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_a [4];
        bit ok;
        exp_a[0] = 8'hFE; exp_a[1] = 8'hFF; exp_a[2] = 8'h00; exp_a[3] = 8'h01;
        bif.out_ready = 1'b1;
        load_expect(8'hFE, 4);
        pulse_start(8'hFE, 9'd4);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            vectors++;
            if (bif.ram_rd_addr !== exp_a[k-1]) begin
                miscompares++;
                $display("FAIL wrap_addr_c%0d: got %h, expected %h", k, bif.ram_rd_addr, exp_a[k-1]);
            end
        end
        wait_for_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL wrap_timeout: got no done, expected done"); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL wrap_leftover: got %0d, expected 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        int  b0, d0;
        bit  got_done;
        b0 = beats_seen; d0 = done_count; got_done = 1'b0;
        bif.out_ready = 1'b0;
        load_expect(8'h40, 8);
        pulse_start(8'h40, 9'd8);
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(posedge clock); #1;
            bif.out_ready = (c >= 5 && c < 15) ? 1'b0 : 1'($urandom_range(0, 1));
            @(negedge clock);
            if (bif.done) got_done = 1'b1;
        end
        @(posedge clock); #1;
        bif.out_ready = 1'b1;
        vectors++; if (!got_done) begin miscompares++; $display("FAIL bp_timeout: got no done, expected done"); end
        vectors++; if (beats_seen - b0 != 8) begin miscompares++; $display("FAIL bp_beats: got %0d, expected 8", beats_seen - b0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL bp_leftover: got %0d, expected 0", sb.size()); end
        vectors++; if (done_count - d0 != 1) begin miscompares++; $display("FAIL bp_done_pulses: got %0d, expected 1", done_count - d0); end
    endtask

    task automatic test_zero_count();
        pulse_start(8'h33, 9'd0);
        @(negedge clock);
        vectors++; if (bif.done !== 1'b1) begin miscompares++; $display("FAIL zero_done_c1: got %b, expected 1", bif.done); end
        vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy_c1: got %b, expected 0", bif.busy); end
        vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL zero_valid_c1: got %b, expected 0", bif.out_valid); end
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            vectors++;
            if (bif.done !== 1'b0 || bif.busy !== 1'b0 || bif.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_idle_c%0d: got done=%b busy=%b valid=%b, expected 0 0 0", k, bif.done, bif.busy, bif.out_valid);
            end
        end
    endtask

    task automatic test_full_buffer();
        int b0;
        bit ok;
        b0 = beats_seen;
        bif.out_ready = 1'b1;
        load_expect(8'h00, 256);
        pulse_start(8'h00, 9'd256);
        wait_for_done(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL full_timeout: got no done, expected done"); end
        vectors++; if (beats_seen - b0 != 256) begin miscompares++; $display("FAIL full_beats: got %0d, expected 256", beats_seen - b0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL full_leftover: got %0d, expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        int  hs, d0, b0;
        bit  ok;
        hs = 0;
        bif.out_ready = 1'b1;
        load_expect(8'h80, 8);
        pulse_start(8'h80, 9'd8);
        for (int c = 0; c < 40 && hs < 3; c++) begin
            @(negedge clock);
            if (bif.out_valid && bif.out_ready) hs++;
        end
        vectors++; if (hs != 3) begin miscompares++; $display("FAIL rmid_beats: got %0d, expected 3", hs); end
        @(posedge clock); #1;
        reset = 1'b1;
        bif.out_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++; if (bif.busy !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b, expected 0", bif.busy); end
        vectors++; if (bif.done !== 1'b0) begin miscompares++; $display("FAIL rmid_done: got %b, expected 0", bif.done); end
        vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b, expected 0", bif.out_valid); end
        vectors++; if (bif.out_last !== 1'b0) begin miscompares++; $display("FAIL rmid_last: got %b, expected 0", bif.out_last); end
        vectors++; if (bif.out_data !== 32'h0) begin miscompares++; $display("FAIL rmid_data: got %h, expected 0", bif.out_data); end
        vectors++; if (bif.ram_rd_addr !== 8'h0) begin miscompares++; $display("FAIL rmid_addr: got %h, expected 0", bif.ram_rd_addr); end
        @(posedge clock); #1;
        reset = 1'b0;
        sb.delete();
        d0 = done_count;
        repeat (4) @(negedge clock);
        vectors++; if (done_count != d0) begin miscompares++; $display("FAIL rmid_no_done: got %0d pulses, expected 0", done_count - d0); end
        vectors++; if (bif.out_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet: got valid=%b, expected 0", bif.out_valid); end
        b0 = beats_seen;
        bif.out_ready = 1'b1;
        load_expect(8'h20, 2);
        pulse_start(8'h20, 9'd2);
        wait_for_done(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rmid_restart_timeout: got no done, expected done"); end
        vectors++; if (beats_seen - b0 != 2) begin miscompares++; $display("FAIL rmid_restart_beats: got %0d, expected 2", beats_seen - b0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL rmid_restart_leftover: got %0d, expected 0", sb.size()); end
    endtask

    task automatic test_back_to_back_start();
        int d0, b0;
        d0 = done_count; b0 = beats_seen;
        bif.out_ready = 1'b1;
        load_expect(8'h30, 6);
        pulse_start(8'h30, 9'd6);
        for (int k = 2; k <= 20; k++) begin
            @(posedge clock); #1;
            bif.start      = (k == 2) || (k == 5);
            bif.start_addr = 8'h90;
            bif.word_count = 9'd3;
            @(negedge clock);
            if (k == 9) begin
                vectors++;
                if (bif.done !== 1'b1) begin miscompares++; $display("FAIL b2b_done_c9: got %b, expected 1", bif.done); end
            end
        end
        @(posedge clock); #1;
        bif.start = 1'b0;
        vectors++; if (done_count - d0 != 1) begin miscompares++; $display("FAIL b2b_done_pulses: got %0d, expected 1", done_count - d0); end
        vectors++; if (beats_seen - b0 != 6) begin miscompares++; $display("FAIL b2b_beats: got %0d, expected 6", beats_seen - b0); end
        vectors++; if (sb.size() != 0) begin miscompares++; $display("FAIL b2b_leftover: got %0d, expected 0", sb.size()); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        beats_seen  = 0;
        done_count  = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        prev_last   = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = 32'hA500_0000 + i;
        reset          = 1'b1;
        bif.start      = 1'b0;
        bif.start_addr = '0;
        bif.word_count = '0;
        bif.out_ready  = 1'b0;

        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_count();
        test_full_buffer();
        test_reset_mid();
        test_back_to_back_start();

        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
